// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codewords MSB-first into a byte stream with a
// valid/ready output handshake and a zero-padding flush of the final partial byte.
module huffman_bit_packer #(
  parameter int MAX_CODE_LEN = 10,
  parameter int ACC_W        = MAX_CODE_LEN + 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MAX_CODE_LEN-1:0] code_in,
  input  logic [3:0]              code_len,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic                    flush,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    flush_done,
  output logic                    err_len,
  output logic [15:0]             byte_count
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             flush_pending;

  logic             out_free;
  logic             accept;
  logic             len_legal;
  logic             emit;
  logic             flush_fire;
  logic [ACC_W-1:0] code_bits;
  logic [ACC_W-1:0] acc_shifted;
  logic [ACC_W-1:0] emit_shift;
  logic [ACC_W-1:0] flush_shift;
  logic [15:0]      count_inc;

  // Ready depends only on registered state so upstream can never form a loop through it.
  assign code_ready = (cnt < CNT_W'(8)) && !flush_pending;
  assign out_free   = !byte_valid || byte_ready;
  assign accept     = code_valid && code_ready;
  assign len_legal  = code_len <= 4'(MAX_CODE_LEN);
  assign emit       = (cnt >= CNT_W'(8)) && out_free;
  assign flush_fire = flush_pending && (cnt < CNT_W'(8)) && out_free;
  assign count_inc  = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    code_bits   = '0;
    acc_shifted = '0;
    emit_shift  = '0;
    flush_shift = '0;
    code_bits   = ACC_W'(code_in) & ((ACC_W'(1) << code_len) - ACC_W'(1));
    acc_shifted = (acc << code_len) | code_bits;
    // Oldest eight bits sit at acc[cnt-1 -: 8]; only meaningful when cnt >= 8.
    emit_shift  = acc >> (cnt - CNT_W'(8));
    // Left-justify the cnt (< 8) leftover bits into a byte, zero-filling below.
    flush_shift = acc << (CNT_W'(8) - cnt);
  end

  // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      byte_out      <= 8'h00;
      byte_valid    <= 1'b0;
      flush_done    <= 1'b0;
      err_len       <= 1'b0;
      byte_count    <= 16'd0;
    end else begin
      flush_done <= 1'b0;

      if (flush && !flush_pending) begin
        flush_pending <= 1'b1;
      end

      if (accept && code_len != 4'd0) begin
        if (len_legal) begin
          acc <= acc_shifted;
          cnt <= cnt + CNT_W'(code_len);
        end else begin
          err_len <= 1'b1;
        end
      end

      // Accept (cnt < 8) and emit (cnt >= 8) cannot both fire, so cnt has one writer per cycle.
      if (emit) begin
        byte_out   <= emit_shift[7:0];
        byte_valid <= 1'b1;
        cnt        <= cnt - CNT_W'(8);
        byte_count <= count_inc;
      end else if (flush_fire) begin
        flush_pending <= 1'b0;
        flush_done    <= 1'b1;
        if (cnt != '0) begin
          byte_out   <= flush_shift[7:0];
          byte_valid <= 1'b1;
          cnt        <= '0;
          byte_count <= count_inc;
        end else if (byte_ready) begin
          byte_valid <= 1'b0;
        end
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed table-driven bench for huffman_bit_packer plus a hand-written
// asynchronous reset sequence; expected values are hand-computed.
module tb_huffman_bit_packer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  code_in;
  logic [3:0]  code_len;
  logic        code_valid;
  logic        code_ready;
  logic        flush;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush_done;
  logic        err_len;
  logic [15:0] byte_count;

  int checks;
  int failures;

  huffman_bit_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_len   (code_len),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush_done (flush_done),
    .err_len    (err_len),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  cin;
    logic [3:0]  clen;
    logic        cv;
    logic        fl;
    logic        br;
    logic        e_bv;
    logic [7:0]  e_bo;
    logic        e_cr;
    logic        e_fd;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [9:0] cin, input logic [3:0] clen, input logic cv,
                     input logic fl, input logic br, input logic e_bv, input logic [7:0] e_bo,
                     input logic e_cr, input logic e_fd, input logic e_err, input logic [15:0] e_cnt);
    vec_t v;
    v = '{cin, clen, cv, fl, br, e_bv, e_bo, e_cr, e_fd, e_err, e_cnt};
    vecs.push_back(v);
  endtask

  // Compares the packed outputs {bv, bo, cr, fd, err, count}.
  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got bv=%0b bo=%02h cr=%0b fd=%0b err=%0b cnt=%0d, want bv=%0b bo=%02h cr=%0b fd=%0b err=%0b cnt=%0d",
               name, act[28], act[27:20], act[19], act[18], act[17], act[15:0],
               exp[28], exp[27:20], exp[19], exp[18], exp[17], exp[15:0]);
    end
  endtask

  function automatic logic [28:0] pack(input logic bv, input logic [7:0] bo, input logic cr,
                                       input logic fd, input logic err, input logic [15:0] cnt);
    return {bv, bo, cr, fd, err, 1'b0, cnt};
  endfunction

  function automatic logic [28:0] outs();
    return pack(byte_valid, byte_out, code_ready, flush_done, err_len, byte_count);
  endfunction

  task automatic drive(input logic [9:0] cin, input logic [3:0] clen, input logic cv,
                       input logic fl, input logic br);
    code_in    = cin;
    code_len   = clen;
    code_valid = cv;
    flush      = fl;
    byte_ready = br;
  endtask

  task automatic step(input logic [9:0] cin, input logic [3:0] clen, input logic cv,
                      input logic fl, input logic br);
    drive(cin, clen, cv, fl, br);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b1);

    // cin clen cv fl br | bv bo cr fd err count
    // 101 + 11001 -> 0xB9
    add(10'h005, 4'd3,  1, 0, 1,  0, 8'h00, 1, 0, 0, 16'd0);
    add(10'h019, 4'd5,  1, 0, 1,  0, 8'h00, 0, 0, 0, 16'd0);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'hB9, 1, 0, 0, 16'd1);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hB9, 1, 0, 0, 16'd1);
    // two 10-bit all-ones codes held valid, then flush -> FF FF F0
    add(10'h3FF, 4'd10, 1, 0, 1,  0, 8'hB9, 0, 0, 0, 16'd1);
    add(10'h3FF, 4'd10, 1, 0, 1,  1, 8'hFF, 1, 0, 0, 16'd2);
    add(10'h3FF, 4'd10, 1, 0, 1,  0, 8'hFF, 0, 0, 0, 16'd2);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'hFF, 1, 0, 0, 16'd3);
    add(10'h000, 4'd0,  0, 1, 1,  0, 8'hFF, 0, 0, 0, 16'd3);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'hF0, 1, 1, 0, 16'd4);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hF0, 1, 0, 0, 16'd4);
    // backpressure: B9 held while a second byte (AA) waits
    add(10'h005, 4'd3,  1, 0, 0,  0, 8'hF0, 1, 0, 0, 16'd4);
    add(10'h019, 4'd5,  1, 0, 0,  0, 8'hF0, 0, 0, 0, 16'd4);
    add(10'h000, 4'd0,  0, 0, 0,  1, 8'hB9, 1, 0, 0, 16'd5);
    add(10'h0AA, 4'd8,  1, 0, 0,  1, 8'hB9, 0, 0, 0, 16'd5);
    for (int i = 0; i < 4; i++)
      add(10'h000, 4'd0, 0, 0, 0, 1, 8'hB9, 0, 0, 0, 16'd5);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'hAA, 1, 0, 0, 16'd6);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hAA, 1, 0, 0, 16'd6);
    // flush with nothing buffered
    add(10'h000, 4'd0,  0, 1, 1,  0, 8'hAA, 0, 0, 0, 16'd6);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hAA, 1, 1, 0, 16'd6);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hAA, 1, 0, 0, 16'd6);
    // illegal length (sticky err, discarded), zero length, then a full byte
    add(10'h3FF, 4'd12, 1, 0, 1,  0, 8'hAA, 1, 0, 1, 16'd6);
    add(10'h001, 4'd0,  1, 0, 1,  0, 8'hAA, 1, 0, 1, 16'd6);
    add(10'h03C, 4'd8,  1, 0, 1,  0, 8'hAA, 0, 0, 1, 16'd6);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'h3C, 1, 0, 1, 16'd7);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'h3C, 1, 0, 1, 16'd7);
    // code + flush same cycle; second flush while pending is ignored -> A0
    add(10'h005, 4'd3,  1, 1, 1,  0, 8'h3C, 0, 0, 1, 16'd7);
    add(10'h000, 4'd0,  0, 1, 1,  1, 8'hA0, 1, 1, 1, 16'd8);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'hA0, 1, 0, 1, 16'd8);
    // upper code_in bits beyond code_len are masked: 0101 + 1111 -> 0x5F
    add(10'h3F5, 4'd4,  1, 0, 1,  0, 8'hA0, 1, 0, 1, 16'd8);
    add(10'h3FF, 4'd4,  1, 0, 1,  0, 8'hA0, 0, 0, 1, 16'd8);
    add(10'h000, 4'd0,  0, 0, 1,  1, 8'h5F, 1, 0, 1, 16'd9);
    add(10'h000, 4'd0,  0, 0, 1,  0, 8'h5F, 1, 0, 1, 16'd9);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_state", outs(), pack(0, 8'h00, 1, 0, 0, 16'd0));

    foreach (vecs[i]) begin
      step(vecs[i].cin, vecs[i].clen, vecs[i].cv, vecs[i].fl, vecs[i].br);
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].e_bv, vecs[i].e_bo, vecs[i].e_cr, vecs[i].e_fd, vecs[i].e_err, vecs[i].e_cnt));
    end

    // Asynchronous reset with a byte held on the output and 5 bits buffered.
    step(10'h005, 4'd3, 1, 0, 0);
    step(10'h019, 4'd5, 1, 0, 0);
    step(10'h000, 4'd0, 0, 0, 0);
    step(10'h015, 4'd5, 1, 0, 0);
    check("pre_reset", outs(), pack(1, 8'hB9, 1, 0, 1, 16'd10));
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), pack(0, 8'h00, 1, 0, 0, 16'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step(10'h0AA, 4'd8, 1, 0, 1);
    check("post_reset_acc", outs(), pack(0, 8'h00, 0, 0, 0, 16'd0));
    step(10'h000, 4'd0, 0, 0, 1);
    check("post_reset_byte", outs(), pack(1, 8'hAA, 1, 0, 0, 16'd1));
    step(10'h000, 4'd0, 0, 0, 1);
    check("post_reset_idle", outs(), pack(0, 8'hAA, 1, 0, 0, 16'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
